// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding select encodings, zero register
// number and the in-flight writer slot record used by the hazard logic.
package cpu_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    localparam logic [4:0] XZR = 5'd31;

    // One in-flight writer: valid, destination register, and whether it is a load
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

endpackage

// File: rtl/id_hazard_unit_src_match.sv
// Compares one ID source operand against the EX and MEM writer slots.
// XZR and unused sources never match, so they never stall or forward.
module hazard_src_match
    import cpu_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_used,
    input  slot_t      ex_slot,
    input  slot_t      mem_slot,
    output logic       match_ex,
    output logic       match_mem,
    output logic       match_ex_load
);

    logic src_live_s;

    assign src_live_s    = src_used && (src != XZR);
    assign match_ex      = src_live_s && ex_slot.valid  && (ex_slot.rd  == src);
    assign match_mem     = src_live_s && mem_slot.valid && (mem_slot.rd == src);
    assign match_ex_load = match_ex && ex_slot.load;

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage hazard and forwarding scoreboard. Tracks writers in EX and MEM,
// raises a combinational stall on load-use (or any RAW hazard without
// forwarding), registers EX operand forwarding selects, and counts stall
// cycles with saturation.
module id_hazard_unit
    import cpu_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       rf1,
    input  logic [4:0]       rf2,
    input  logic             rf1_used,
    input  logic             rf2_used,
    input  logic [4:0]       rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The register file is write-through, so a writer that has moved past MEM
    // can never be a hazard or a forwarding source; the WB position is
    // therefore not stored here.
    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;

    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic a_match_ex, a_match_mem, a_match_ex_load;
    logic b_match_ex, b_match_mem, b_match_ex_load;
    logic hazard_s;
    logic stall_s;

    hazard_src_match u_match_a (
        .src           (rf1),
        .src_used      (rf1_used),
        .ex_slot       (ex_q),
        .mem_slot      (mem_q),
        .match_ex      (a_match_ex),
        .match_mem     (a_match_mem),
        .match_ex_load (a_match_ex_load)
    );

    hazard_src_match u_match_b (
        .src           (rf2),
        .src_used      (rf2_used),
        .ex_slot       (ex_q),
        .mem_slot      (mem_q),
        .match_ex      (b_match_ex),
        .match_mem     (b_match_mem),
        .match_ex_load (b_match_ex_load)
    );

    // Stall decision: load-use only with forwarding, any EX/MEM RAW without it; flush overrides
    always_comb begin
        hazard_s = 1'b0;
        if (FWD_EN != 0) begin
            hazard_s = a_match_ex_load || b_match_ex_load;
        end else begin
            hazard_s = a_match_ex || a_match_mem || b_match_ex || b_match_mem;
        end
        stall_s = id_valid && !flush && hazard_s;
    end

    // Next slot contents: ID entry (or bubble) into EX, EX into MEM
    always_comb begin
        ex_d.valid = id_valid && id_regwrite && (rd != XZR) && !stall_s && !flush;
        ex_d.rd    = rd;
        ex_d.load  = id_memread;
        mem_d      = ex_q;
    end

    // Forwarding selects for the instruction advancing into EX; youngest writer wins
    always_comb begin
        fwd_a_d = FWD_REGFILE;
        fwd_b_d = FWD_REGFILE;
        if (!id_valid || stall_s || flush || (FWD_EN == 0)) begin
            fwd_a_d = FWD_REGFILE;
            fwd_b_d = FWD_REGFILE;
        end else begin
            if (a_match_ex) begin
                fwd_a_d = FWD_EXMEM;
            end else if (a_match_mem) begin
                fwd_a_d = FWD_MEMWB;
            end else begin
                fwd_a_d = FWD_REGFILE;
            end
            if (b_match_ex) begin
                fwd_b_d = FWD_EXMEM;
            end else if (b_match_mem) begin
                fwd_b_d = FWD_MEMWB;
            end else begin
                fwd_b_d = FWD_REGFILE;
            end
        end
    end

    // Saturating count of stalled cycles
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_s && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '{valid: 1'b0, rd: 5'd0, load: 1'b0};
            mem_q         <= '{valid: 1'b0, rd: 5'd0, load: 1'b0};
            fwd_a_q       <= FWD_REGFILE;
            fwd_b_q       <= FWD_REGFILE;
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall       = stall_s;
    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit. Two instances share one stimulus stream:
// u_dut forwards (32-bit counter), u_nf does not forward (4-bit counter).
module tb_id_hazard_unit;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rf1, rf2, rd;
    logic        rf1_used, rf2_used;
    logic        id_regwrite, id_memread, flush;

    logic        stall_f, stall_nf;
    logic [1:0]  fwd_a_f, fwd_b_f, fwd_a_nf, fwd_b_nf;
    logic [31:0] cnt_f;
    logic [3:0]  cnt_nf;

    int errors = 0;
    int checks = 0;

    id_hazard_unit #(.FWD_EN(1), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rf1(rf1), .rf2(rf2), .rf1_used(rf1_used), .rf2_used(rf2_used),
        .rd(rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall(stall_f), .fwd_a(fwd_a_f), .fwd_b(fwd_b_f),
        .stall_count(cnt_f)
    );

    id_hazard_unit #(.FWD_EN(0), .CNT_W(4)) u_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rf1(rf1), .rf2(rf2), .rf1_used(rf1_used), .rf2_used(rf2_used),
        .rd(rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall(stall_nf), .fwd_a(fwd_a_nf), .fwd_b(fwd_b_nf),
        .stall_count(cnt_nf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub, input logic [4:0] d,
                         input logic rw, input logic mr, input logic fl);
        id_valid = v; rf1 = a; rf1_used = ua; rf2 = b; rf2_used = ub;
        rd = d; id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int seen;

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        settle();

        // Reset state
        check("rst_stall_f", {31'd0, stall_f}, 32'd0);
        check("rst_fwd_a", {30'd0, fwd_a_f}, 32'd0);
        check("rst_fwd_b", {30'd0, fwd_b_f}, 32'd0);
        check("rst_cnt_f", cnt_f, 32'd0);
        check("rst_cnt_nf", {28'd0, cnt_nf}, 32'd0);

        // Load-use: LDUR X1 then ADD X2,X1,X3
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        settle();
        check("lu_ld_stall", {31'd0, stall_f}, 32'd0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        settle();
        check("lu_stall1", {31'd0, stall_f}, 32'd1);
        tick();
        check("lu_cnt", cnt_f, 32'd1);
        check("lu_bubble_fwd_a", {30'd0, fwd_a_f}, 32'd0);
        settle();
        check("lu_stall2", {31'd0, stall_f}, 32'd0);
        tick();
        check("lu_fwd_a", {30'd0, fwd_a_f}, 32'd1);
        check("lu_fwd_b", {30'd0, fwd_b_f}, 32'd0);
        check("lu_cnt_hold", cnt_f, 32'd1);

        // Back-to-back ALU: ADD X5 then SUB X6,X7,X5
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        settle();
        check("alu_stall_f", {31'd0, stall_f}, 32'd0);
        check("alu_stall_nf1", {31'd0, stall_nf}, 32'd1);
        tick();
        check("alu_fwd_b_f", {30'd0, fwd_b_f}, 32'd2);
        check("alu_fwd_a_f", {30'd0, fwd_a_f}, 32'd0);
        check("alu_cnt_nf1", {28'd0, cnt_nf}, 32'd1);
        settle();
        check("alu_stall_nf2", {31'd0, stall_nf}, 32'd1);
        tick();
        check("alu_cnt_nf2", {28'd0, cnt_nf}, 32'd2);
        settle();
        check("alu_stall_nf3", {31'd0, stall_nf}, 32'd0);
        tick();
        check("alu_fwd_b_nf", {30'd0, fwd_b_nf}, 32'd0);
        check("alu_fwd_a_nf", {30'd0, fwd_a_nf}, 32'd0);
        check("alu_cnt_nf3", {28'd0, cnt_nf}, 32'd2);
        check("alu_cnt_f", cnt_f, 32'd0);

        // XZR writer then XZR reader
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        settle();
        check("xzr_stall_f", {31'd0, stall_f}, 32'd0);
        check("xzr_stall_nf", {31'd0, stall_nf}, 32'd0);
        tick();
        check("xzr_fwd_a", {30'd0, fwd_a_f}, 32'd0);

        // Unused source matching a load in EX
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        settle();
        check("unused_stall_f", {31'd0, stall_f}, 32'd0);
        check("unused_stall_nf", {31'd0, stall_nf}, 32'd0);
        tick();
        check("unused_fwd_a", {30'd0, fwd_a_f}, 32'd0);
        check("unused_fwd_b", {30'd0, fwd_b_f}, 32'd0);

        // Flush coinciding with load-use; flushed reader writes X2
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1);
        settle();
        check("fl_stall_f", {31'd0, stall_f}, 32'd0);
        check("fl_stall_nf", {31'd0, stall_nf}, 32'd0);
        tick();
        check("fl_cnt_f", cnt_f, 32'd0);
        check("fl_cnt_nf", {28'd0, cnt_nf}, 32'd0);
        check("fl_fwd_a", {30'd0, fwd_a_f}, 32'd0);
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        settle();
        check("fl_next_stall", {31'd0, stall_f}, 32'd0);
        tick();
        check("fl_next_fwd_a", {30'd0, fwd_a_f}, 32'd1);
        check("fl_ex_empty_fwd_b", {30'd0, fwd_b_f}, 32'd0);

        // Priority: X4 in both EX and MEM, read on both operands
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        settle();
        check("pri_stall", {31'd0, stall_f}, 32'd0);
        tick();
        check("pri_fwd_a", {30'd0, fwd_a_f}, 32'd2);
        check("pri_fwd_b", {30'd0, fwd_b_f}, 32'd2);

        // Reset asserted during a load-use stall
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        settle();
        check("mr_stall_before", {31'd0, stall_f}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("mr_stall_after", {31'd0, stall_f}, 32'd0);
        check("mr_cnt_f", cnt_f, 32'd0);
        check("mr_fwd_a", {30'd0, fwd_a_f}, 32'd0);

        // Saturation on the 4-bit counter: self-dependent writer held in ID
        do_reset();
        seen = 0;
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            settle();
            if (stall_nf) seen++;
            tick();
        end
        check("sat_seen", (seen >= 20) ? 32'd1 : 32'd0, 32'd1);
        check("sat_cnt_nf", {28'd0, cnt_nf}, 32'd15);
        check("sat_cnt_f", cnt_f, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
